demux_l2_1a4: RTL and testbench
===============================

Name: demux_l2_1a4

Overview:
- Byte-lane deserializer; the receive-side counterpart of the 4-lane-to-serial mux path.
- Takes one 8-bit stream with a valid qualifier at clk_4f rate and distributes consecutive valid bytes round-robin into lanes 0..3.
- Presents each completed 4-byte group in parallel on registered lane outputs with per-lane valids.
- An idle timeout flushes partially filled groups so no data is stranded.

Parameters:
- WIDTH, 8, lane/data width in bits.
- IDLE_LIMIT, 4, consecutive idle cycles while filling before a partial group is flushed; legal range 1..15.

Ports:
- clk_4f  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  serial input byte.
- valid_in  input  1  data_in qualifier; a byte is accepted on each posedge with valid_in=1.
- data_out0..data_out3  output  WIDTH each  registered lane outputs.
- valid_out0..valid_out3  output  1 each  lane valids for the current output group.
- frame_strobe  output  1  one-cycle pulse when the output registers are loaded.
- partial  output  1  high with frame_strobe when the load is a timeout flush; otherwise 0.

Behaviour:
- Reset (posedge with reset=1):
  - All outputs go to 0; lane pointer ptr=0; idle counter idle_cnt=0; holding buffers buf0..buf2 and their write flags cleared; state=EMPTY.
  - Reset has priority over all other events. Reset mid-group discards the buffered bytes without a strobe.
- States: EMPTY (ptr=0, nothing buffered) and FILLING (1..3 bytes buffered).
- EMPTY:
  - valid_in=0: hold.
  - valid_in=1: buf0<=data_in, ptr<=1, idle_cnt<=0, go to FILLING.
- FILLING, valid_in=1 with ptr<3:
  - buf[ptr]<=data_in, ptr<=ptr+1, idle_cnt<=0.
- FILLING, valid_in=1 with ptr==3 (group complete):
  - Same edge: data_out0..2<=buf0..2, data_out3<=data_in, valid_out0..3<=1, frame_strobe<=1, partial<=0.
  - ptr<=0, go to EMPTY.
  - Latency: outputs are visible the cycle after the 4th byte is presented.
- FILLING, valid_in=0:
  - idle_cnt<=idle_cnt+1.
  - If idle_cnt==IDLE_LIMIT-1 (timeout) on this edge: flush.
    - data_outN<=bufN for N<ptr, valid_outN<=1 for N<ptr.
    - data_outN<=0 and valid_outN<=0 for N>=ptr.
    - frame_strobe<=1, partial<=1, ptr<=0, idle_cnt<=0, go to EMPTY.
- Completion and timeout cannot coincide: valid_in=1 clears idle_cnt.
- idle_cnt never runs in EMPTY.
- frame_strobe and partial are high for exactly one cycle per load; otherwise 0.
- data_out*/valid_out* hold their last loaded values until the next load or reset; no auto-clear.
- Back-to-back: a byte with valid_in=1 on the completion edge+1 starts the next group in lane 0, so a continuous stream yields one frame_strobe every 4 cycles.
- ptr is 2 bits and wraps 3->0 only via completion or flush.
- Output contents are unaffected by new bytes until the next load; the buffers are separate from the output registers.

Test Plan:
- Reset then continuous stream: valid_in=1, data_in=0xEE,0x01,0xFF,0xFD on 4 consecutive edges -> next cycle data_out0..3=EE,01,FF,FD, valid_out0..3=1111, frame_strobe=1 for one cycle, partial=0.
- Continuous 12 bytes 0x00..0x0B -> three strobes, 4 cycles apart; groups {00,01,02,03}, {04,05,06,07}, {08,09,0A,0B}; outputs hold between strobes.
- Gapped stream: 0x10, idle 2, 0x11, idle 1, 0x12, 0x13 (IDLE_LIMIT=4) -> no flush; single strobe with 10,11,12,13, partial=0.
- Timeout: 0xA0, 0xA1 then valid_in=0 -> strobe on the 4th idle edge; data_out=A0,A1,00,00, valid_out0..3=1100, partial=1, state EMPTY; next byte lands in lane 0.
- Reset mid-group: 3 bytes 0x55,0x66,0x77, reset=1 for one edge, then 0x01..0x04 -> no strobe for the discarded bytes, outputs zero after reset; next strobe gives 01,02,03,04.
- Idle in EMPTY for 20 cycles after a completed group -> no strobe, outputs unchanged, partial stays 0.

Source files
------------

// File: rtl/demux_l2_1a4.sv
// Byte-lane deserializer: distributes a serial byte stream round-robin into four
// lanes and presents each group in parallel, flushing partial groups after an idle timeout.
module demux_l2_1a4 #(
  parameter int WIDTH      = 8,
  parameter int IDLE_LIMIT = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             valid_out2,
  output logic             valid_out3,
  output logic             frame_strobe,
  output logic             partial
);

  typedef enum logic {EMPTY = 1'b0, FILLING = 1'b1} state_t;

  localparam logic [3:0] IDLE_MAX = 4'(IDLE_LIMIT - 1);

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [3:0]       idle_q;
  logic [WIDTH-1:0] buf_q  [3];
  logic [2:0]       wr_q;
  logic [WIDTH-1:0] dout_q [4];
  logic [3:0]       vout_q;
  logic             strobe_q;
  logic             partial_q;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      idle_q    <= '0;
      wr_q      <= '0;
      vout_q    <= '0;
      strobe_q  <= 1'b0;
      partial_q <= 1'b0;
      for (int n = 0; n < 3; n++) buf_q[n]  <= '0;
      for (int n = 0; n < 4; n++) dout_q[n] <= '0;
    end else begin
      strobe_q  <= 1'b0;
      partial_q <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (valid_in) begin
            buf_q[0] <= data_in;
            wr_q     <= 3'b001;
            ptr_q    <= 2'd1;
            idle_q   <= '0;
            state_q  <= FILLING;
          end
        end
        FILLING: begin
          if (valid_in) begin
            idle_q <= '0;
            if (ptr_q == 2'd3) begin
              // Fourth byte goes straight to lane 3; buffers supply lanes 0..2.
              for (int n = 0; n < 3; n++) dout_q[n] <= buf_q[n];
              dout_q[3] <= data_in;
              vout_q    <= 4'b1111;
              strobe_q  <= 1'b1;
              ptr_q     <= '0;
              wr_q      <= '0;
              state_q   <= EMPTY;
            end else begin
              for (int n = 0; n < 3; n++) begin
                if (ptr_q == 2'(n)) begin
                  buf_q[n] <= data_in;
                  wr_q[n]  <= 1'b1;
                end
              end
              ptr_q <= ptr_q + 2'd1;
            end
          end else if (idle_q == IDLE_MAX) begin
            // Timeout flush: only lanes that were written carry data.
            for (int n = 0; n < 3; n++) begin
              dout_q[n] <= wr_q[n] ? buf_q[n] : '0;
              vout_q[n] <= wr_q[n];
            end
            dout_q[3] <= '0;
            vout_q[3] <= 1'b0;
            strobe_q  <= 1'b1;
            partial_q <= 1'b1;
            ptr_q     <= '0;
            idle_q    <= '0;
            wr_q      <= '0;
            state_q   <= EMPTY;
          end else begin
            idle_q <= idle_q + 4'd1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign data_out0    = dout_q[0];
  assign data_out1    = dout_q[1];
  assign data_out2    = dout_q[2];
  assign data_out3    = dout_q[3];
  assign valid_out0   = vout_q[0];
  assign valid_out1   = vout_q[1];
  assign valid_out2   = vout_q[2];
  assign valid_out3   = vout_q[3];
  assign frame_strobe = strobe_q;
  assign partial      = partial_q;

endmodule

// File: tb/tb_demux_l2_1a4.sv
// Directed bench for demux_l2_1a4: vector table plus hand sequences for timeout and reset.
module tb_demux_l2_1a4;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       frame_strobe, partial;

  int n_pass = 0;
  int n_total = 0;

  demux_l2_1a4 #(.WIDTH(8), .IDLE_LIMIT(4)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3),
    .frame_strobe(frame_strobe), .partial(partial)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  din;
    logic [31:0] ed;   // {lane3,lane2,lane1,lane0}
    logic [3:0]  ev;   // {v3,v2,v1,v0}
    logic        es;
    logic        ep;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic vld, logic [7:0] din,
                              logic [31:0] ed, logic [3:0] ev, logic es, logic ep);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = din;
    v.ed = ed; v.ev = ev; v.es = es; v.ep = ep;
    return v;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    logic [37:0] act, exp;
    @(negedge clk_4f);
    reset = v.rst; valid_in = v.vld; data_in = v.din;
    @(posedge clk_4f);
    #1;
    act = {data_out3, data_out2, data_out1, data_out0,
           valid_out3, valid_out2, valid_out1, valid_out0, frame_strobe, partial};
    exp = {v.ed, v.ev, v.es, v.ep};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got d=%h v=%b s=%b p=%b, want d=%h v=%b s=%b p=%b",
                  tag, act[37:6], act[5:2], act[1], act[0], v.ed, v.ev, v.es, v.ep);
  endtask

  initial begin
    logic [31:0] hold;

    // Reset, then EE,01,FF,FD
    vq.push_back(mk(1, 0, 8'h00, 32'h0, 4'h0, 0, 0));
    vq.push_back(mk(0, 1, 8'hEE, 32'h0, 4'h0, 0, 0));
    vq.push_back(mk(0, 1, 8'h01, 32'h0, 4'h0, 0, 0));
    vq.push_back(mk(0, 1, 8'hFF, 32'h0, 4'h0, 0, 0));
    vq.push_back(mk(0, 1, 8'hFD, 32'hFDFF01EE, 4'hF, 1, 0));
    // Continuous 00..0B: strobes every 4 cycles, outputs hold between
    hold = 32'hFDFF01EE;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        hold = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
        vq.push_back(mk(0, 1, 8'(i), hold, 4'hF, 1, 0));
      end else begin
        vq.push_back(mk(0, 1, 8'(i), hold, 4'hF, 0, 0));
      end
    end
    // Gapped: 10, idle2, 11, idle1, 12, 13 -> no flush
    vq.push_back(mk(0, 1, 8'h10, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h11, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h12, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h13, 32'h13121110, 4'hF, 1, 0));
    hold = 32'h13121110;
    // Boundary: IDLE_LIMIT-1 idle cycles must not flush
    vq.push_back(mk(0, 1, 8'h20, hold, 4'hF, 0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 8'h00, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h21, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h22, hold, 4'hF, 0, 0));
    vq.push_back(mk(0, 1, 8'h23, 32'h23222120, 4'hF, 1, 0));
    hold = 32'h23222120;
    // Idle in EMPTY for 20 cycles: nothing changes
    for (int i = 0; i < 20; i++) vq.push_back(mk(0, 0, 8'h5A, hold, 4'hF, 0, 0));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // Timeout with two bytes: strobe on 4th idle edge
    apply(mk(0, 1, 8'hA0, hold, 4'hF, 0, 0), "to2_a0");
    apply(mk(0, 1, 8'hA1, hold, 4'hF, 0, 0), "to2_a1");
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 8'h00, hold, 4'hF, 0, 0), $sformatf("to2_idle%0d", i));
    apply(mk(0, 0, 8'h00, 32'h0000A1A0, 4'b0011, 1, 1), "to2_flush");
    apply(mk(0, 0, 8'h00, 32'h0000A1A0, 4'b0011, 0, 0), "to2_after");
    // Next group starts in lane 0
    apply(mk(0, 1, 8'hB0, 32'h0000A1A0, 4'b0011, 0, 0), "lane0_b0");
    apply(mk(0, 1, 8'hB1, 32'h0000A1A0, 4'b0011, 0, 0), "lane0_b1");
    apply(mk(0, 1, 8'hB2, 32'h0000A1A0, 4'b0011, 0, 0), "lane0_b2");
    apply(mk(0, 1, 8'hB3, 32'hB3B2B1B0, 4'hF, 1, 0), "lane0_b3");

    // Timeout with three bytes
    apply(mk(0, 1, 8'hC0, 32'hB3B2B1B0, 4'hF, 0, 0), "to3_c0");
    apply(mk(0, 1, 8'hC1, 32'hB3B2B1B0, 4'hF, 0, 0), "to3_c1");
    apply(mk(0, 1, 8'hC2, 32'hB3B2B1B0, 4'hF, 0, 0), "to3_c2");
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 8'h00, 32'hB3B2B1B0, 4'hF, 0, 0), $sformatf("to3_idle%0d", i));
    apply(mk(0, 0, 8'h00, 32'h00C2C1C0, 4'b0111, 1, 1), "to3_flush");

    // Reset mid-group, with valid_in high during reset
    apply(mk(0, 1, 8'h55, 32'h00C2C1C0, 4'b0111, 0, 0), "rst_55");
    apply(mk(0, 1, 8'h66, 32'h00C2C1C0, 4'b0111, 0, 0), "rst_66");
    apply(mk(0, 1, 8'h77, 32'h00C2C1C0, 4'b0111, 0, 0), "rst_77");
    apply(mk(1, 1, 8'h99, 32'h0, 4'h0, 0, 0), "rst_edge");
    apply(mk(0, 1, 8'h01, 32'h0, 4'h0, 0, 0), "rst_01");
    apply(mk(0, 1, 8'h02, 32'h0, 4'h0, 0, 0), "rst_02");
    apply(mk(0, 1, 8'h03, 32'h0, 4'h0, 0, 0), "rst_03");
    apply(mk(0, 1, 8'h04, 32'h04030201, 4'hF, 1, 0), "rst_04");
    apply(mk(0, 0, 8'h00, 32'h04030201, 4'hF, 0, 0), "rst_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
